// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter with a valid/ready load handshake and a
// one-word holding buffer so consecutive words stream without an idle bit.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] hold_reg, hold_next;
    logic             hold_full_reg, hold_full_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] shifted;

    logic accept;
    logic consume;
    logic last_bit;

    // load_ready depends only on hold_full_reg, so accept has no loop back.
    assign accept   = load_valid && !hold_full_reg;
    assign consume  = (state_reg == SHIFT) && shift_en;
    assign last_bit = (count_reg == LAST);

    // Next-bit alignment: the bit on serial_out is shifted away, a zero fills in.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shifted[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shifted[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            count_reg     <= count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        count_next     = count_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    shift_next = data_in;
                    count_next = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (consume && last_bit) begin
                    count_next = '0;
                    if (hold_full_reg) begin
                        shift_next     = hold_reg;
                        hold_full_next = 1'b0;
                    end else if (accept) begin
                        shift_next = data_in;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (consume) begin
                        shift_next = shifted;
                        count_next = count_reg + CW'(1);
                    end
                    // The last-bit bypass above is the only accept that skips the buffer.
                    if (accept) begin
                        hold_next      = data_in;
                        hold_full_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_ready   = !hold_full_reg;
        serial_valid = (state_reg == SHIFT);
        serial_out   = serial_valid && (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
        frame_start  = serial_valid && (count_reg == '0);
        frame_end    = serial_valid && (count_reg == LAST);
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: expected bits are queued as words are
// offered and checked against serial_out as the sink consumes them.
module tb_piso_serializer;

    typedef struct packed {
        logic b;
        logic fs;
        logic fe;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] data_in;
    logic       shift_en;
    logic       lv_m, lv_l;
    logic       lr_m, so_m, sv_m, fs_m, fe_m;
    logic       lr_l, so_l, sv_l, fs_l, fe_l;

    exp_t q_m[$];
    exp_t q_l[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int vcount_m, vcount_l, first_v, last_v;

    always #5 clock = ~clock;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clock(clock), .reset(reset), .data_in(data_in), .load_valid(lv_m),
        .load_ready(lr_m), .shift_en(shift_en), .serial_out(so_m),
        .serial_valid(sv_m), .frame_start(fs_m), .frame_end(fe_m)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clock(clock), .reset(reset), .data_in(data_in), .load_valid(lv_l),
        .load_ready(lr_l), .shift_en(shift_en), .serial_out(so_l),
        .serial_valid(sv_l), .frame_start(fs_l), .frame_end(fe_l)
    );

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Queue the bits of a word in transmit order with their frame flags.
    task automatic push_word(input bit lsb_dut, input logic [3:0] w);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.b  = lsb_dut ? w[i] : w[3-i];
            e.fs = (i == 0);
            e.fe = (i == 3);
            if (lsb_dut) q_l.push_back(e);
            else         q_m.push_back(e);
        end
    endtask

    task automatic clear_stats();
        vcount_m = 0;
        vcount_l = 0;
        first_v  = -1;
        last_v   = -1;
    endtask

    // One clock: sample at the falling edge, then move past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clock);
        cyc++;
        if (sv_m) begin
            vcount_m++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            check("sb_has_entry_m", int'(q_m.size() != 0), 1);
            if (q_m.size() != 0) begin
                e = q_m[0];
                check("bit_m", int'(so_m), int'(e.b));
                check("frame_start_m", int'(fs_m), int'(e.fs));
                check("frame_end_m", int'(fe_m), int'(e.fe));
                $display("cyc %0d msb-first bit=%0b fs=%0b fe=%0b shift_en=%0b",
                         cyc, so_m, fs_m, fe_m, shift_en);
                if (shift_en) void'(q_m.pop_front());
            end
        end else begin
            check("idle_flags_m", int'({so_m, fs_m, fe_m}), 0);
        end
        if (sv_l) begin
            vcount_l++;
            check("sb_has_entry_l", int'(q_l.size() != 0), 1);
            if (q_l.size() != 0) begin
                e = q_l[0];
                check("bit_l", int'(so_l), int'(e.b));
                check("frame_start_l", int'(fs_l), int'(e.fs));
                check("frame_end_l", int'(fe_l), int'(e.fe));
                $display("cyc %0d lsb-first bit=%0b fs=%0b fe=%0b shift_en=%0b",
                         cyc, so_l, fs_l, fe_l, shift_en);
                if (shift_en) void'(q_l.pop_front());
            end
        end else begin
            check("idle_flags_l", int'({so_l, fs_l, fe_l}), 0);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        data_in  = 4'b0000;
        shift_en = 1'b1;
        lv_m     = 1'b0;
        lv_l     = 1'b0;
        #3;
        check("reset_state_m", int'({sv_m, so_m, fs_m, fe_m, lr_m}), 1);
        check("reset_state_l", int'({sv_l, so_l, fs_l, fe_l, lr_l}), 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cycle();

        // Single word, sink always ready.
        clear_stats();
        data_in = 4'b1011;
        lv_m    = 1'b1;
        push_word(1'b0, 4'b1011);
        cycle();
        lv_m = 1'b0;
        check("first_bit_latency", int'(sv_m), 1);
        repeat (4) cycle();
        check("idle_after_word", int'(sv_m), 0);
        check("single_drained", q_m.size(), 0);
        check("single_valid_cycles", vcount_m, 4);

        // Back-to-back: load_valid held, second word lands in the buffer.
        clear_stats();
        data_in = 4'b1011;
        lv_m    = 1'b1;
        push_word(1'b0, 4'b1011);
        cycle();
        data_in = 4'b0001;
        push_word(1'b0, 4'b0001);
        cycle();
        lv_m = 1'b0;
        check("ready_low_while_held", int'(lr_m), 0);
        repeat (4) cycle();
        check("ready_back_after_reload", int'(lr_m), 1);
        repeat (4) cycle();
        check("b2b_drained", q_m.size(), 0);
        check("b2b_valid_cycles", vcount_m, 8);
        check("b2b_contiguous", last_v - first_v + 1, 8);

        // Bypass: next word offered exactly at the last-bit edge.
        clear_stats();
        data_in = 4'b1011;
        lv_m    = 1'b1;
        push_word(1'b0, 4'b1011);
        cycle();
        lv_m = 1'b0;
        repeat (3) cycle();
        data_in = 4'b0110;
        lv_m    = 1'b1;
        push_word(1'b0, 4'b0110);
        cycle();
        lv_m = 1'b0;
        check("bypass_keeps_ready", int'(lr_m), 1);
        repeat (5) cycle();
        check("bypass_drained", q_m.size(), 0);
        check("bypass_contiguous", last_v - first_v + 1, 8);

        // Stall for 3 cycles while the second bit (0) is presented.
        clear_stats();
        data_in = 4'b1011;
        lv_m    = 1'b1;
        push_word(1'b0, 4'b1011);
        cycle();
        lv_m = 1'b0;
        cycle();
        shift_en = 1'b0;
        repeat (3) cycle();
        shift_en = 1'b1;
        repeat (4) cycle();
        check("stall_drained", q_m.size(), 0);
        check("stall_valid_cycles", vcount_m, 7);

        // Reset in the middle of a word discards the rest of it.
        clear_stats();
        data_in = 4'b1011;
        lv_m    = 1'b1;
        push_word(1'b0, 4'b1011);
        cycle();
        lv_m = 1'b0;
        repeat (2) cycle();
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_m", int'({sv_m, so_m, fs_m, fe_m, lr_m}), 1);
        q_m.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        clear_stats();
        data_in = 4'b0110;
        lv_m    = 1'b1;
        push_word(1'b0, 4'b0110);
        cycle();
        lv_m = 1'b0;
        repeat (5) cycle();
        check("post_reset_drained", q_m.size(), 0);
        check("post_reset_valid_cycles", vcount_m, 4);

        // LSB-first instance.
        clear_stats();
        data_in = 4'b1011;
        lv_l    = 1'b1;
        push_word(1'b1, 4'b1011);
        cycle();
        lv_l = 1'b0;
        check("lsb_first_latency", int'(sv_l), 1);
        repeat (5) cycle();
        check("lsb_drained", q_l.size(), 0);
        check("lsb_valid_cycles", vcount_l, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Downstream consumer of the 4-bit parallel-in/parallel-out register stage; converts each parallel word into a serial bitstream.
- Has a valid/ready load handshake and a one-entry holding buffer, so back-to-back words stream with no idle bit between them.
- A shift_en input lets the serial sink stall the stream.
- Sits between the parallel register and any serial link or transmitter.

Parameters:
- WIDTH, 4, word width in bits (>=2).
- MSB_FIRST, 1, 1 = transmit data_in[WIDTH-1] first; 0 = transmit data_in[0] first.

Ports:
- clock  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  WIDTH  parallel word from upstream register stage.
- load_valid  input  1  data_in holds a word to transfer.
- load_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  sink consumes current bit at this edge when serial_valid=1.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a valid data bit.
- frame_start  output  1  current bit is first bit of a word.
- frame_end  output  1  current bit is last bit of a word.

Behaviour:
- Reset (reset=0, async, immediate, independent of clock):
  - state=IDLE; shift register, holding register and bit counter cleared; hold_full=0.
  - Outputs: serial_out=0, serial_valid=0, frame_start=0, frame_end=0, load_ready=1.
- Mid-word reset discards the word in flight and any held word. First edge after release behaves as IDLE.
- Accept: a word transfers at a rising edge with load_valid=1 && load_ready=1.
- load_ready = !hold_full in all states. It is decoded from registers only; no combinational path from load_valid or shift_en.
- State machine:
  - IDLE: serial_valid=0. On accept, data_in goes into the shift register, count=0, go to SHIFT.
    - Latency: first bit is valid in the cycle immediately after the accept edge.
  - SHIFT: serial_valid=1. A bit is consumed at an edge with shift_en=1.
    - Non-last bit consumed: shift register advances one position (toward MSB when MSB_FIRST=1, toward LSB otherwise); count+1.
    - Last bit consumed (count==WIDTH-1):
      - hold_full=1: load shift register from holding register, clear hold_full, count=0, stay SHIFT.
      - else if accept this edge: load data_in directly into shift register (bypass), count=0, stay SHIFT.
      - else: go to IDLE, serial_valid drops next cycle.
    - Accept in SHIFT at any edge other than the last-bit bypass case: word goes into holding register, hold_full=1.
    - A held word is never overwritten; load_ready=0 while hold_full=1.
- Stall: shift_en=0 in SHIFT freezes the shift register, count, serial_out, serial_valid, frame_start and frame_end. Accepting into the holding register is still allowed.
- shift_en is ignored in IDLE.
- Output decode:
  - serial_out = MSB of shift register if MSB_FIRST, else LSB; 0 in IDLE.
  - frame_start = serial_valid && count==0.
  - frame_end = serial_valid && count==WIDTH-1.
- Counter width: $clog2(WIDTH). The counter never exceeds WIDTH-1.
- data_in is sampled only at accept edges; changes at other times have no effect.

Test Plan:
- Reset: drive reset=0 at arbitrary time during SHIFT -> serial_valid, serial_out, frame_start, frame_end all 0 and load_ready=1 without waiting for a clock edge.
- Single word, WIDTH=4, shift_en=1: accept 4'b1011 at edge N -> serial_out 1,0,1,1 in cycles N+1..N+4.
  - frame_start=1 only in N+1, frame_end=1 only in N+4.
  - serial_valid=0 from N+5.
- Back-to-back: load_valid held with 4'b1011 then 4'b0001 -> 8 contiguous valid bits 1,0,1,1,0,0,0,1 with no gap.
  - load_ready=0 while the second word is held.
  - Two frame_start pulses, 4 cycles apart.
- Stall: shift_en=0 for 3 cycles while bit 2 of 4'b1011 is presented -> serial_out held at 0 for 4 cycles, frame flags unchanged, 7 valid cycles in total, same bit order.
- Reset mid-word: reset=0 after second bit of 4'b1011, release, accept 4'b0110 -> only 0,1,1,0 follows; no remnant bits of 1011.
- MSB_FIRST=0: accept 4'b1011 -> serial_out 1,1,0,1; frame_end on the fourth bit.
